// File: rtl/lfsr_pkg.sv
// Shared definitions for the 64-bit XNOR LFSR test-pattern generator and checker,
// so the polynomial and state encoding live in exactly one place.
package lfsr_pkg;

   localparam int LFSR_W = 64;

   localparam int TAP_A = 0;
   localparam int TAP_B = 8;
   localparam int TAP_C = 13;
   localparam int TAP_D = 31;

   localparam logic XNOR_INV = 1'b1;

   // Reducing the history through this mask is the same as XORing the four taps.
   localparam logic [LFSR_W-1:0] TAP_MASK = (LFSR_W'(1) << TAP_A) |
                                            (LFSR_W'(1) << TAP_B) |
                                            (LFSR_W'(1) << TAP_C) |
                                            (LFSR_W'(1) << TAP_D);

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_LOCKED  = 2'd2
   } state_e;

endpackage

// File: rtl/lfsr_predict.sv
// Combinational next-bit predictor: taps a history register and yields the bit
// the generator will emit next.
module lfsr_predict
   import lfsr_pkg::*;
(
   input  logic [LFSR_W-1:0] hist,
   output logic              pred
);

   assign pred = (^(hist & TAP_MASK)) ^ XNOR_INV;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR pattern checker: self-synchronises to the serial stream,
// then flywheels on its own prediction and counts mismatches.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int CONFIRM_LEN = 16,
   parameter int WINDOW      = 256,
   parameter int ERR_LIMIT   = 8,
   parameter int CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             VALID,
   input  logic             DATA,
   input  logic             CLEAR,
   output logic             LOCKED,
   output logic             ERR,
   output logic [CNT_W-1:0] ERR_COUNT,
   output logic [1:0]       STATE
);

   localparam int FILL_W = 7;
   localparam int CONF_W = $clog2(CONFIRM_LEN) + 1;
   localparam int WIN_W  = $clog2(WINDOW) + 1;
   localparam int WERR_W = $clog2(ERR_LIMIT) + 1;

   state_e              state_q, state_d;
   logic [LFSR_W-1:0]   hist_q, hist_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [CONF_W-1:0]   confirm_q, confirm_d;
   logic [WIN_W-1:0]    win_q, win_d;
   logic [WERR_W-1:0]   werr_q, werr_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    err_count_q, err_count_d;
   logic                pred;
   logic                mismatch;

   lfsr_predict u_predict (
      .hist (hist_q),
      .pred (pred)
   );

   assign mismatch = DATA ^ pred;

   always_comb begin
      state_d     = state_q;
      hist_d      = hist_q;
      fill_d      = fill_q;
      confirm_d   = confirm_q;
      win_d       = win_q;
      werr_d      = werr_q;
      err_d       = 1'b0;
      err_count_d = err_count_q;

      case (state_q)
         ST_HUNT: begin
            if (VALID) begin
               hist_d = {DATA, hist_q[LFSR_W-1:1]};
               fill_d = fill_q + FILL_W'(1);
               if (fill_q == FILL_W'(LFSR_W - 1)) begin
                  state_d   = ST_CONFIRM;
                  confirm_d = '0;
               end
            end
         end
         ST_CONFIRM: begin
            if (VALID) begin
               hist_d = {DATA, hist_q[LFSR_W-1:1]};
               if (!mismatch) begin
                  confirm_d = confirm_q + CONF_W'(1);
                  if (confirm_q == CONF_W'(CONFIRM_LEN - 1)) begin
                     state_d = ST_LOCKED;
                     win_d   = '0;
                     werr_d  = '0;
                  end
               end else begin
                  state_d = ST_HUNT;
                  fill_d  = '0;
               end
            end
         end
         ST_LOCKED: begin
            // Shift in the prediction, not DATA, so a channel error never reaches the taps.
            if (VALID) begin
               hist_d = {pred, hist_q[LFSR_W-1:1]};
               win_d  = win_q + WIN_W'(1);
               if (mismatch) begin
                  err_d  = 1'b1;
                  werr_d = werr_q + WERR_W'(1);
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + CNT_W'(1);
                  end
               end
               if (mismatch && (werr_q == WERR_W'(ERR_LIMIT - 1))) begin
                  state_d = ST_HUNT;
                  fill_d  = '0;
               end else if (win_q == WIN_W'(WINDOW - 1)) begin
                  win_d  = '0;
                  werr_d = '0;
               end
            end
         end
         default: begin
            state_d = ST_HUNT;
         end
      endcase

      if (CLEAR) begin
         err_count_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_HUNT;
         hist_q      <= '0;
         fill_q      <= '0;
         confirm_q   <= '0;
         win_q       <= '0;
         werr_q      <= '0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         confirm_q   <= confirm_d;
         win_q       <= win_d;
         werr_q      <= werr_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   assign LOCKED    = (state_q == ST_LOCKED);
   assign ERR       = err_q;
   assign ERR_COUNT = err_count_q;
   assign STATE     = state_q;

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive end of the 64-bit XNOR LFSR test pattern. Takes the serial bit stream from the generator's bit 0, self-synchronises to it, then checks each later bit against its own prediction.
- Drives lock status, a per-bit error strobe and a saturating error count, so a bench or lamp array can show link integrity.
- Sits between the MCPNR_SWITCHES input path and MCPNR_LIGHTS outputs in loopback test tops.

Parameters:
- CONFIRM_LEN, 16: consecutive correct predictions required before declaring lock.
- WINDOW, 256: length of the loss-of-lock supervision window, in valid bits.
- ERR_LIMIT, 8: errors within one window that force a return to hunting.
- CNT_W, 16: width of ERR_COUNT.

Ports:
- CLK  in  1  sole clock, posedge.
- RST  in  1  asynchronous reset, active-high.
- VALID  in  1  DATA is sampled this cycle.
- DATA  in  1  received serial bit (the generator's OUTPUT[0] stream).
- CLEAR  in  1  synchronous clear of ERR_COUNT.
- LOCKED  out  1  high while in state LOCKED.
- ERR  out  1  one-cycle pulse on a mismatch while locked.
- ERR_COUNT  out  CNT_W  locked-state mismatches since reset or CLEAR; saturates at all-ones.
- STATE  out  2  encoded state for debug lamps.

Behaviour:
- Reset (async, RST=1):
  - history H=0, fill counter=0, confirm counter=0, window counter=0, window error counter=0.
  - State=HUNT; LOCKED=0, ERR=0, ERR_COUNT=0, STATE=0.
- History register H[63:0]:
  - Shift in one bit per VALID cycle: H[62:0]<=H[63:1], H[63]<=new bit.
  - H[0] is the oldest bit.
  - Prediction P = H[0]^H[8]^H[13]^H[31]^1. This mirrors the generator register exactly.
- VALID=0: no state, counter or history changes; ERR=0.
- State HUNT (STATE=0):
  - Each VALID bit: shift in DATA; fill++.
  - When the 64th bit is shifted in (fill reaches 64), go to CONFIRM with confirm=0.
- State CONFIRM (STATE=1):
  - Each VALID bit: compare DATA with P, then shift in DATA.
  - Match: confirm++. On reaching CONFIRM_LEN, go to LOCKED with window=0 and window errors=0.
  - Mismatch: go to HUNT with fill=0. History keeps its contents.
  - No ERR pulse and no ERR_COUNT change in this state.
- State LOCKED (STATE=2, LOCKED=1):
  - Each VALID bit: shift in P, not DATA. This flywheel stops one channel error spreading through the taps.
  - Mismatch (DATA!=P):
    - ERR=1 on the next cycle (registered, one cycle of latency).
    - ERR_COUNT++ unless it is all-ones.
    - Window errors++.
  - window++ each VALID bit.
  - Window errors reach ERR_LIMIT: go to HUNT with fill=0. The final ERR pulse and count still occur.
  - Window reaches WINDOW without that: clear window and window errors, stay LOCKED.
  - If the loss limit and the window end fall on the same bit, loss of lock wins.
- STATE=3 is unused; the state machine goes from it to HUNT.
- CLEAR:
  - Sets ERR_COUNT=0 next cycle.
  - Takes priority over a same-cycle increment (result is 0).
  - Does not affect the state machine.
- Transition timing: the state transition takes effect on the clock edge that samples the triggering bit. The next VALID bit is processed in the new state.
- Generator-after-reset stream:
  - 64 zeros, then the bits it generates, starting with 1.
  - H=0 predicts 1, so the checker follows it from the first generated bit.
- Widths: fill counter is 7 bits; confirm, window and window-error counters are sized as clog2 of their parameter plus 1.

Decomposition:
- Shared package lfsr_pkg holds:
  - LFSR_W=64.
  - Tap constants 0, 8, 13, 31.
  - The XNOR-invert flag.
  - State encoding HUNT=0, CONFIRM=1, LOCKED=2.
- The generator and checker both use this package so the polynomial is defined once.
- One sub-module is natural: lfsr_predict. It is combinational, taps H and yields P, and is shared with future generator variants.
- Counters and the state machine stay in lfsr_checker.

Test Plan:
- Reset generator and checker, VALID=1 continuously, error-free loopback:
  - STATE=1 from the cycle after the 64th bit.
  - LOCKED=1 after bit 64+16=80.
  - ERR never pulses; ERR_COUNT=0 after 10000 bits.
- Once locked, flip one DATA bit at bit 500:
  - Exactly one ERR pulse.
  - ERR_COUNT=1.
  - LOCKED stays 1 (flywheel, no tap propagation).
- Once locked, flip 8 bits within one 256-bit window:
  - ERR_COUNT=8, LOCKED falls after the 8th error.
  - Relock about 80 bits later. ERR_COUNT holds 8.
- Flip 7 bits in one window, then 7 in the next: LOCKED stays 1, ERR_COUNT=14.
- One mismatch during CONFIRM (bit 70): back to HUNT; LOCKED is asserted after a further 64+16 clean bits.
- Force ERR_COUNT toward saturation with CNT_W=4 and 20 errors in separate windows:
  - ERR_COUNT holds 15.
  - CLEAR together with an error gives 0.
  - Assert RST mid-LOCKED: all outputs are 0 with no clock edge.
